// File: rtl/qft_nq_stream_engine.sv
// Streaming in-place N-qubit QFT: bit-reversed load, one radix-2 butterfly per cycle,
// natural-order unload. Each stage scales by 1/sqrt(2) so the transform is normalised.
module qft_nq_stream_engine #(
    parameter int NUM_QUBITS = 2,
    parameter int TOTAL_BITS = 8,
    parameter int FX_BITS    = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [TOTAL_BITS-1:0] in_re,
    input  logic signed [TOTAL_BITS-1:0] in_im,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [TOTAL_BITS-1:0] out_re,
    output logic signed [TOTAL_BITS-1:0] out_im,
    output logic                         out_last,
    output logic                         busy,
    output logic                         ovf
);

    localparam int L     = 1 << NUM_QUBITS;
    localparam int HALF  = L / 2;
    localparam int TW    = TOTAL_BITS;
    localparam int QW    = NUM_QUBITS;
    localparam int PW    = 2 * TOTAL_BITS + 4;
    localparam int ONE   = 1 << FX_BITS;
    // round(0.70710678 * 2**FX_BITS) using a 16-bit fraction of 1/sqrt(2)
    localparam int C_INT = (46341 * ONE + 32768) >>> 16;

    localparam logic signed [PW-1:0] C_X  = PW'(C_INT);
    localparam logic signed [PW-1:0] MAXV = PW'((1 << (TW - 1)) - 1);
    localparam logic signed [PW-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {StLoad, StCompute, StUnload} state_t;

    state_t                state_q;
    logic [QW-1:0]         in_cnt_q;
    logic [QW-1:0]         out_cnt_q;
    logic [QW-1:0]         bfly_q;
    logic [1:0]            stage_q;

    logic signed [TW-1:0]  buf_re [L];
    logic signed [TW-1:0]  buf_im [L];

    function automatic logic [QW-1:0] bitrev(input logic [QW-1:0] k);
        logic [QW-1:0] r;
        for (int i = 0; i < QW; i++) begin
            r[i] = k[QW-1-i];
        end
        return r;
    endfunction

    // Returns {clamped, value}
    function automatic logic [TW:0] sat_f(input logic signed [PW-1:0] v);
        if (v > MAXV) begin
            return {1'b1, 1'b0, {(TW - 1){1'b1}}};
        end else if (v < MINV) begin
            return {1'b1, 1'b1, {(TW - 1){1'b0}}};
        end
        return {1'b0, v[TW-1:0]};
    endfunction

    int                    s_i, k_i, m_i, j_i, top_i;
    logic [QW-1:0]         top_idx, bot_idx, wr_addr;
    logic [1:0]            tw_idx;
    logic signed [TW-1:0]  w_re, w_im;
    logic signed [PW-1:0]  are_x, aim_x, bre_x, bim_x, wre_x, wim_x;
    logic signed [PW-1:0]  t_re, t_im, sum_re, sum_im, dif_re, dif_im;
    logic [TW:0]           sat_tr, sat_ti, sat_br, sat_bi;
    logic                  bf_ovf;

    always_comb begin
        s_i     = int'(stage_q);
        k_i     = int'(bfly_q);
        m_i     = 1 << s_i;
        j_i     = k_i & (m_i - 1);
        top_i   = ((k_i >> s_i) << (s_i + 1)) | j_i;
        top_idx = QW'(top_i);
        bot_idx = QW'(top_i + m_i);
        tw_idx  = 2'((j_i << (2 - s_i)) & 3);
        wr_addr = bitrev(in_cnt_q);
    end

    always_comb begin
        w_re = '0;
        w_im = '0;
        unique case (tw_idx)
            2'd0: begin w_re = TW'(ONE);     w_im = '0;          end
            2'd1: begin w_re = TW'(C_INT);   w_im = TW'(C_INT);  end
            2'd2: begin w_re = '0;           w_im = TW'(ONE);    end
            2'd3: begin w_re = TW'(-C_INT);  w_im = TW'(C_INT);  end
            default: ;
        endcase
    end

    // Everything is widened to PW bits, so no intermediate term can wrap
    always_comb begin
        are_x  = PW'(buf_re[top_idx]);
        aim_x  = PW'(buf_im[top_idx]);
        bre_x  = PW'(buf_re[bot_idx]);
        bim_x  = PW'(buf_im[bot_idx]);
        wre_x  = PW'(w_re);
        wim_x  = PW'(w_im);
        t_re   = (bre_x * wre_x - bim_x * wim_x) >>> FX_BITS;
        t_im   = (bre_x * wim_x + bim_x * wre_x) >>> FX_BITS;
        sum_re = are_x + t_re;
        sum_im = aim_x + t_im;
        dif_re = are_x - t_re;
        dif_im = aim_x - t_im;
        sat_tr = sat_f((sum_re * C_X) >>> FX_BITS);
        sat_ti = sat_f((sum_im * C_X) >>> FX_BITS);
        sat_br = sat_f((dif_re * C_X) >>> FX_BITS);
        sat_bi = sat_f((dif_im * C_X) >>> FX_BITS);
        bf_ovf = sat_tr[TW] | sat_ti[TW] | sat_br[TW] | sat_bi[TW];
    end

    // Sample buffer has no reset; its contents are don't-care until loaded
    always_ff @(posedge clk) begin
        if (state_q == StLoad && in_valid) begin
            buf_re[wr_addr] <= in_re;
            buf_im[wr_addr] <= in_im;
        end else if (state_q == StCompute) begin
            buf_re[top_idx] <= sat_tr[TW-1:0];
            buf_im[top_idx] <= sat_ti[TW-1:0];
            buf_re[bot_idx] <= sat_br[TW-1:0];
            buf_im[bot_idx] <= sat_bi[TW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StLoad;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            bfly_q    <= '0;
            stage_q   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            ovf       <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (in_valid) begin
                        if (in_cnt_q == '0) begin
                            ovf <= 1'b0;
                        end
                        if (in_cnt_q == QW'(L - 1)) begin
                            state_q  <= StCompute;
                            in_cnt_q <= '0;
                            bfly_q   <= '0;
                            stage_q  <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            in_cnt_q <= in_cnt_q + QW'(1);
                        end
                    end
                end
                StCompute: begin
                    if (bf_ovf) begin
                        ovf <= 1'b1;
                    end
                    if (bfly_q == QW'(HALF - 1)) begin
                        bfly_q <= '0;
                        if (stage_q == 2'(NUM_QUBITS - 1)) begin
                            state_q   <= StUnload;
                            out_cnt_q <= '0;
                        end else begin
                            stage_q <= stage_q + 2'd1;
                        end
                    end else begin
                        bfly_q <= bfly_q + QW'(1);
                    end
                end
                StUnload: begin
                    // First cycle only primes the output register
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_re    <= buf_re[out_cnt_q];
                        out_im    <= buf_im[out_cnt_q];
                        out_last  <= (out_cnt_q == QW'(L - 1));
                    end else if (out_ready) begin
                        if (out_last) begin
                            state_q   <= StLoad;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_cnt_q <= '0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            out_cnt_q <= out_cnt_q + QW'(1);
                            out_re    <= buf_re[out_cnt_q + QW'(1)];
                            out_im    <= buf_im[out_cnt_q + QW'(1)];
                            out_last  <= ((out_cnt_q + QW'(1)) == QW'(L - 1));
                        end
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

endmodule

// File: tb/tb_qft_nq_stream_engine.sv
// Scoreboard bench for the 2-qubit streaming QFT engine: directed vectors, backpressure,
// latency and mid-transform reset.
module tb_qft_nq_stream_engine;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [7:0] in_re = '0;
    logic signed [7:0] in_im = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic signed [7:0] out_re;
    logic signed [7:0] out_im;
    logic              out_last;
    logic              busy;
    logic              ovf;

    qft_nq_stream_engine #(
        .NUM_QUBITS(2),
        .TOTAL_BITS(8),
        .FX_BITS   (6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_re    (in_re),
        .in_im    (in_im),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_re   (out_re),
        .out_im   (out_im),
        .out_last (out_last),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef int vec4_t[4];
    typedef struct {
        int re;
        int im;
        bit last;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   bp_mode = 1'b0;
    int   bp_idx = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // out_ready changes just after the rising edge so it is settled at the sampling edge
    initial begin
        bit pat[4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        forever begin
            @(posedge clk);
            #2;
            if (bp_mode) begin
                out_ready = pat[bp_idx % 4];
                bp_idx++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: pops on each handshake and checks held data while stalled
    initial begin
        bit stall = 1'b0;
        int held_re = 0;
        int held_im = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    tests++;
                    if (!out_valid || int'(out_re) != held_re || int'(out_im) != held_im) begin
                        fails++;
                        $display("FAIL stall_hold: got v=%0b (%0d,%0d), expected v=1 (%0d,%0d)",
                                 out_valid, out_re, out_im, held_re, held_im);
                    end
                end
                if (out_valid && out_ready) begin
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_out: got (%0d,%0d) with empty scoreboard",
                                 out_re, out_im);
                    end else begin
                        e = sb.pop_front();
                        if (int'(out_re) != e.re || int'(out_im) != e.im || out_last != e.last) begin
                            fails++;
                            $display("FAIL out_data: got (%0d,%0d,last=%0b), expected (%0d,%0d,last=%0b)",
                                     out_re, out_im, out_last, e.re, e.im, e.last);
                        end
                    end
                    stall = 1'b0;
                end else if (out_valid) begin
                    stall   = 1'b1;
                    held_re = int'(out_re);
                    held_im = int'(out_im);
                end else begin
                    stall = 1'b0;
                end
            end
        end
    end

    task automatic send(input int re, input int im, output bit ok);
        @(negedge clk);
        in_valid = 1'b1;
        in_re    = 8'(re);
        in_im    = 8'(im);
        for (int n = 0; n < 50 && !in_ready; n++) @(negedge clk);
        if (!in_ready) begin
            ok = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            ok = 1'b1;
        end
    endtask

    task automatic load(input vec4_t ire, input vec4_t iim, input bit timing);
        bit ok;
        int cyc;
        bit low;
        for (int k = 0; k < 4; k++) begin
            send(ire[k], iim[k], ok);
            check("in_accept", int'(ok), 1);
            if (k == 0) check("ovf_clear_first", int'(ovf), 0);
        end
        in_valid = 1'b0;
        if (timing) begin
            cyc = 0;
            low = 1'b1;
            for (int n = 1; n <= 20; n++) begin
                @(posedge clk);
                #1;
                if (!out_valid && in_ready) low = 1'b0;
                if (out_valid) begin
                    cyc = n;
                    break;
                end
            end
            check("latency", cyc, 5);
            check("in_ready_low", int'(low), 1);
        end
    endtask

    task automatic run(input vec4_t ire, input vec4_t iim, input vec4_t ere, input vec4_t eim,
                       input bit bp, input bit exp_ovf, input bit timing);
        exp_t e;
        bp_idx  = 0;
        bp_mode = bp;
        for (int k = 0; k < 4; k++) begin
            e.re   = ere[k];
            e.im   = eim[k];
            e.last = (k == 3);
            sb.push_back(e);
        end
        load(ire, iim, timing);
        for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
        check("drain", sb.size(), 0);
        @(posedge clk);
        #1;
        check("ovf_end", int'(ovf), int'(exp_ovf));
        check("back_to_load", int'(in_ready), 1);
        check("busy_end", int'(busy), 0);
        bp_mode = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec4_t z, r_t1, e_t1, r_t2, e_t2r, e_t2i, r_t3, e_t3, r_t7, e_t7r, e_t7i;
        z     = '{0, 0, 0, 0};
        r_t1  = '{64, 0, 0, 0};
        e_t1  = '{31, 31, 31, 31};
        r_t2  = '{0, 64, 0, 0};
        e_t2r = '{31, 0, -32, 0};
        e_t2i = '{0, 31, 0, -32};
        r_t3  = '{127, 127, 127, 127};
        e_t3  = '{127, 0, 0, 0};
        r_t7  = '{0, 0, 0, 64};
        e_t7r = '{31, 0, -32, 0};
        e_t7i = '{0, -32, 0, 31};

        #12;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_out_re", int'(out_re), 0);
        check("rst_out_im", int'(out_im), 0);
        @(negedge clk);
        rst = 1'b0;

        run(r_t1, z, e_t1, z, 1'b0, 1'b0, 1'b0);      // |00>
        run(r_t2, z, e_t2r, e_t2i, 1'b0, 1'b0, 1'b0); // |01>
        run(r_t3, z, e_t3, z, 1'b0, 1'b1, 1'b0);      // saturation
        run(r_t2, z, e_t2r, e_t2i, 1'b1, 1'b0, 1'b0); // backpressure
        run(r_t1, z, e_t1, z, 1'b0, 1'b0, 1'b1);      // latency
        run(r_t7, z, e_t7r, e_t7i, 1'b1, 1'b0, 1'b0); // |11> with stalls

        // Abort in stage 2: two butterfly edges after the last accept
        load(r_t1, z, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("arst_in_ready", int'(in_ready), 1);
        check("arst_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        check("rst_mid_in_ready", int'(in_ready), 1);
        check("rst_mid_out_valid", int'(out_valid), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_ovf", int'(ovf), 0);
        @(negedge clk);
        rst = 1'b0;
        run(r_t2, z, e_t2r, e_t2i, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
